// File: rtl/seq_scan_arbiter_pkg.sv
// Shared definitions for the serial pattern-detector family.
// Contents:
//   state_t      - arbiter FSM state encoding (IDLE / SHIFT / RESP)
//   DEF_PAT_W    - default pattern length in bits
//   DEF_PATTERN  - default pattern, MSB is the first bit in time
package seq_scan_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int                     DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_scan_arbiter_match.sv
// pat_match_engine: shift-history Mealy matcher, overlapping detection.
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous active-high reset, clears history
//   clr    in  1  synchronous history clear (start of a new word)
//   en     in  1  shift din into the history this cycle
//   din    in  1  serial input bit
//   match  out 1  combinational: {history, din} equals PATTERN
module pat_match_engine
    import seq_scan_arbiter_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);

    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] window;

    // The window always includes the bit being fed, so a match is reported
    // in the same cycle as its last bit.
    assign window = {hist, din};
    assign match  = (window == PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
        end
    end

endmodule

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin sharing of one serial pattern matcher
// among NREQ word-level requesters.
// Ports:
//   clk        in  1            clock
//   rst        in  1            synchronous active-high reset
//   req_valid  in  NREQ         per-requester word valid
//   req_data   in  NREQ*WORD_W  word i in bits [i*WORD_W +: WORD_W]
//   req_ready  out NREQ         one-hot accept (only in IDLE)
//   rsp_valid  out 1            result available
//   rsp_id     out ID_W         requester index of the result
//   rsp_count  out CNT_W        matches found in the word
//   rsp_ready  in  1            consumer accepts the result
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | offer req_ready to next valid requester from rr_ptr
// SHIFT | feed one word bit per cycle MSB-first into the matcher
// RESP  | hold result until rsp_ready, then advance rr_ptr
module seq_scan_arbiter
    import seq_scan_arbiter_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               ID_W    = $clog2(NREQ),
    parameter int               CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [CNT_W-1:0]         rsp_count,
    input  logic                     rsp_ready
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   grant_sel;
    logic [ID_W-1:0]   idx;
    logic              grant_any;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  match_cnt;
    logic              accept;
    logic              shift_en;
    logic              rsp_hs;
    logic              eng_match;

    // Scan downward in offset so the lowest offset from rr_ptr is the last
    // (and therefore winning) assignment.
    always_comb begin
        grant_sel = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_sel = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Ready is only offered to a valid requester, so offering it
                // is the handshake. Held off during reset.
                if (grant_any && !rst) begin
                    req_ready[grant_sel] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
        end else begin
            if (accept) begin
                shreg     <= req_data[int'(grant_sel) * WORD_W +: WORD_W];
                grant_id  <= grant_sel;
                bit_cnt   <= '0;
                match_cnt <= '0;
            end
            if (shift_en) begin
                shreg     <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
                match_cnt <= match_cnt + CNT_W'(eng_match);
            end
            if (rsp_hs) begin
                rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    pat_match_engine #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_engine (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (shift_en),
        .din   (shreg[WORD_W-1]),
        .match (eng_match)
    );

    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = grant_id;
    assign rsp_count = match_cnt;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
module tb_seq_scan_arbiter;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*WORD_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W-1:0]       rsp_count;
    logic                   rsp_ready = 1'b0;

    always #5 clk = ~clk;

    seq_scan_arbiter #(
        .NREQ   (NREQ),
        .WORD_W (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready)
    );

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   acc_cyc  = -1;
    int   rise_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks
    // that a stalled response holds its values.
    logic             prev_valid = 1'b0;
    logic             hold = 1'b0;
    logic [ID_W-1:0]  hold_id = '0;
    logic [CNT_W-1:0] hold_cnt = '0;

    always @(negedge clk) begin
        if (hold) begin
            check("hold_valid", int'(rsp_valid), 1);
            check("hold_id", int'(rsp_id), int'(hold_id));
            check("hold_count", int'(rsp_count), int'(hold_cnt));
        end
        hold = 1'b0;
        if (rsp_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid === 1'b1) begin
            if (!rsp_ready) begin
                hold     = 1'b1;
                hold_id  = rsp_id;
                hold_cnt = rsp_count;
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d count=%0d expected no response",
                         rsp_id, rsp_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", int'(rsp_id), int'(mon_e.id));
                check("rsp_count", int'(rsp_count), int'(mon_e.cnt));
            end
        end
    end

    task automatic post(input int i, input logic [WORD_W-1:0] data,
                        input int cnt, input bit push);
        exp_t e;
        req_data[i*WORD_W +: WORD_W] = data;
        req_valid[i] = 1'b1;
        if (push) begin
            e.id  = ID_W'(i);
            e.cnt = CNT_W'(cnt);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample handshakes at the falling edge, retire the accepted
    // requesters just after the rising edge.
    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (acc != '0) acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (req_valid != '0 || exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d responses pending, valid=%b expected none",
                     exp_q.size(), req_valid);
            exp_q.delete();
            req_valid = '0;
        end
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_count", int'(rsp_count), 0);
        check("reset_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Single request and its latency
        post(0, 16'hDB6D, 5, 1);
        drain(100);
        check("latency", rise_cyc - acc_cyc, WORD_W + 1);

        // Boundary words
        post(0, 16'h000D, 1, 1); drain(100);
        post(0, 16'hFFFF, 0, 1); drain(100);
        post(0, 16'h0000, 0, 1); drain(100);

        // A pattern spanning two words must not be counted
        post(1, 16'h0006, 0, 1); drain(100);
        post(1, 16'h8000, 0, 1); drain(100);

        // Put the pointer back at 0 by serving requester 3
        post(3, 16'hD000, 1, 1); drain(100);

        // Round robin over all four, then only 0 and 2
        post(0, 16'hDB6D, 5, 1);
        post(1, 16'h000D, 1, 1);
        post(2, 16'hFFFF, 0, 1);
        post(3, 16'h1B1B, 2, 1);
        drain(300);
        post(0, 16'h1B1B, 2, 1);
        post(2, 16'h000D, 1, 1);
        drain(200);

        // Backpressure: pointer is 3, so requester 2 wins, then 1 waits
        rsp_ready = 1'b0;
        post(2, 16'hDB6D, 5, 1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("bp_rsp_seen", int'(rsp_valid), 1);
        post(1, 16'h000D, 1, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", int'(req_ready), 0);
            check("bp_rsp_valid", int'(rsp_valid), 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_regrant", int'(req_ready), 2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain(100);

        // Reset at bit 7 of a word in flight
        post(0, 16'hDB6D, 0, 0);
        n = 0;
        while (req_valid[0] && n < 50) begin
            step();
            n++;
        end
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_rsp_id", int'(rsp_id), 0);
        check("midrst_rsp_count", int'(rsp_count), 0);
        check("midrst_req_ready", int'(req_ready), 0);
        repeat (30) @(negedge clk);
        check("midrst_no_rsp", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        post(0, 16'hDB6D, 5, 1);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
